// File: rtl/serial_alu_engine.sv
// Bit-serial W-bit ALU: operands in over a valid/ready handshake, one bit per cycle LSB first, result out over a second handshake.
// Optional signed-overflow output is enabled by defining SERIAL_ALU_OVF_EN.
module serial_alu_engine #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   oc,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         flag,
   output logic         zero
`ifdef SERIAL_ALU_OVF_EN
   ,
   output logic         ovf
`endif
);

   // state | meaning
   // IDLE  | waiting for operands, in_ready high
   // RUN   | processing bit cnt_q, one bit per cycle
   // DONE  | result/flags held, out_valid high until taken
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   localparam logic [2:0] OC_ADD = 3'b000;
   localparam logic [2:0] OC_SUB = 3'b001;
   localparam logic [2:0] OC_MUL = 3'b010;
   localparam logic [2:0] OC_OR  = 3'b011;
   localparam logic [2:0] OC_AND = 3'b100;
   localparam logic [2:0] OC_XOR = 3'b101;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d;
   logic [2:0]    oc_q, oc_d;
   logic [W-1:0]  res_q, res_d;
   logic          flag_q, flag_d;
   logic          zero_q, zero_d;
   logic          ovf_q, ovf_d;

   logic          a_i, b_i, bx, sum, cout, bit_r, arith;
   logic [W-1:0]  shifted;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      oc_d    = oc_q;
      res_d   = res_q;
      flag_d  = flag_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;

      a_i   = a_q[cnt_q];
      b_i   = b_q[cnt_q];
      bx    = (oc_q == OC_SUB) ? ~b_i : b_i;
      sum   = a_i ^ bx ^ carry_q;
      cout  = (a_i & bx) | (a_i & carry_q) | (bx & carry_q);
      arith = (oc_q == OC_ADD) || (oc_q == OC_SUB);

      bit_r = 1'b0;
      case (oc_q)
         OC_ADD, OC_SUB: bit_r = sum;
         OC_MUL, OC_AND: bit_r = a_i & b_i;
         OC_OR:          bit_r = a_i | b_i;
         OC_XOR:         bit_r = a_i ^ b_i;
         default:        bit_r = 1'b0;
      endcase
      shifted = {bit_r, res_q[W-1:1]};

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               oc_d    = oc;
               cnt_d   = '0;
               carry_d = (oc == OC_SUB);
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            res_d   = shifted;
            carry_d = cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               flag_d  = (oc_q == OC_ADD) ? cout : ((oc_q == OC_SUB) ? ~cout : 1'b0);
               zero_d  = (shifted == '0);
               // signed overflow: carry into the MSB differs from carry out of it
               ovf_d   = arith ? (carry_q ^ cout) : 1'b0;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         oc_q    <= '0;
         res_q   <= '0;
         flag_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         oc_q    <= oc_d;
         res_q   <= res_d;
         flag_q  <= flag_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = res_q;
   assign flag      = flag_q;
   assign zero      = zero_q;

`ifdef SERIAL_ALU_OVF_EN
   assign ovf = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu_engine.sv
// Scoreboard bench for serial_alu_engine (W=8); expected results come from a word-level reference model.
module tb_serial_alu_engine;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   oc = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         flag;
   logic         zero;
`ifdef SERIAL_ALU_OVF_EN
   logic         ovf;
`endif

   serial_alu_engine #(.W(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .oc(oc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .flag(flag),
      .zero(zero)
`ifdef SERIAL_ALU_OVF_EN
      ,
      .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int accept_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] res;
      logic         flag;
      logic         zero;
      logic         ovf;
   } exp_t;

   exp_t sb_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [2:0] moc);
      exp_t e;
      logic [W:0] wide;
      e.res = '0; e.flag = 1'b0; e.ovf = 1'b0;
      case (moc)
         3'b000: begin
            wide = {1'b0, ma} + {1'b0, mb};
            e.res = wide[W-1:0];
            e.flag = wide[W];
            e.ovf = (ma[W-1] == mb[W-1]) && (e.res[W-1] != ma[W-1]);
         end
         3'b001: begin
            e.res = ma - mb;
            e.flag = (ma < mb);
            e.ovf = (ma[W-1] != mb[W-1]) && (e.res[W-1] != ma[W-1]);
         end
         3'b010, 3'b100: e.res = ma & mb;
         3'b011:         e.res = ma | mb;
         3'b101:         e.res = ma ^ mb;
         default:        e.res = '0;
      endcase
      e.zero = (e.res == '0);
      return e;
   endfunction

   task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic [2:0] soc);
      sb_q.push_back(model(sa, sb, soc));
      @(negedge clk);
      a = sa; b = sb; oc = soc; in_valid = 1'b1;
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; oc = 3'($urandom);
   endtask

   task automatic collect(input string tag, input int hold, input bit chk_lat);
      exp_t e;
      int waited;
      logic [W-1:0] held;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!out_valid && waited < 40);
      if (!out_valid) begin
         check({tag, "_timeout"}, 32'(out_valid), 32'd1);
         void'(sb_q.pop_front());
         return;
      end
      if (chk_lat) check({tag, "_latency"}, 32'(cyc - accept_cyc), 32'(W));
      e = sb_q.pop_front();
      check({tag, "_result"}, 32'(result), 32'(e.res));
      check({tag, "_flag"}, 32'(flag), 32'(e.flag));
      check({tag, "_zero"}, 32'(zero), 32'(e.zero));
`ifdef SERIAL_ALU_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
      check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
      held = result;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_result"}, 32'(result), 32'(held));
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_result"}, 32'(result), 32'd0);
      check({tag, "_flag"}, 32'(flag), 32'd0);
      check({tag, "_zero"}, 32'(zero), 32'd0);
`ifdef SERIAL_ALU_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'd0);
`endif
   endtask

   initial begin
      #12;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_no_valid", 32'(in_ready), 32'd1);

      send(8'hFF, 8'h01, 3'b000); collect("add_ff_01", 0, 1'b1);
      send(8'h05, 8'h07, 3'b001); collect("sub_05_07", 0, 1'b1);
      send(8'h07, 8'h05, 3'b001); collect("sub_07_05", 0, 1'b0);
      send(8'hA5, 8'h0F, 3'b101); collect("xor", 0, 1'b0);
      send(8'hA5, 8'h0F, 3'b011); collect("or", 0, 1'b0);
      send(8'hA5, 8'h0F, 3'b100); collect("and", 0, 1'b0);
      send(8'hA5, 8'h0F, 3'b010); collect("mul", 0, 1'b0);
      send(8'h30, 8'h03, 3'b011); collect("backpressure", 3, 1'b0);

      send(8'h55, 8'h22, 3'b000);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_run_reset");
      void'(sb_q.pop_back());
      repeat (2) @(negedge clk);
      check("reset_hold_no_output", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      send(8'h10, 8'h20, 3'b000); collect("add_after_reset", 0, 1'b1);

      send(8'hFF, 8'hFF, 3'b110); collect("reserved_110", 0, 1'b1);
      send(8'h12, 8'h34, 3'b111); collect("reserved_111", 0, 1'b0);
`ifdef SERIAL_ALU_OVF_EN
      send(8'h7F, 8'h01, 3'b000); collect("ovf_add", 0, 1'b0);
      send(8'h80, 8'h01, 3'b001); collect("ovf_sub", 0, 1'b0);
`endif
      for (int i = 0; i < 8; i++) begin
         send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
         collect("random", i % 3, 1'b1);
      end

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_alu_engine.md
Name: serial_alu_engine

Overview:
- Bit-serial W-bit ALU built around the team's 1-bit ALU operation set and opcode encoding.
- Accepts W-bit operands plus a 3-bit opcode through a valid/ready handshake.
- Processes one bit per cycle, LSB first, with a carry/borrow flop that chains the per-bit result.
- Returns the W-bit result and flags through a second valid/ready handshake; it is the multi-bit stage that consumes the 1-bit ALU's operation set.

Parameters:
- W, 8, operand/result width in bits; legal range 2..32.
- CW, $clog2(W), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  engine can accept; high only in IDLE.
- a  input  W  operand A.
- b  input  W  operand B.
- oc  input  3  opcode: 000 add, 001 sub (A-B), 010 mul (bitwise AND), 011 or, 100 and, 101 xor, 110/111 reserved.
- out_valid  output  1  result valid; held until taken.
- out_ready  input  1  downstream accepts result.
- result  output  W  operation result.
- flag  output  1  add: carry out; sub: borrow (1 iff A<B unsigned); others: 0.
- zero  output  1  result == 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, flag=0, zero=0; counter, carry and operand registers cleared. Reset mid-RUN or mid-DONE aborts the operation silently; no output is produced.
- States are IDLE, RUN and DONE.
- IDLE -> RUN on the edge where in_valid & in_ready. On that edge, a, b and oc are latched and the counter is set to 0. Carry init: 1 for sub, 0 otherwise.
- In IDLE, in_valid low keeps the state in IDLE. Inputs are ignored outside IDLE.
- RUN: one bit per cycle, bit index = counter, LSB first.
  - add: sum = a_i^b_i^c, c' = majority(a_i, b_i, c).
  - sub: same as add with b_i inverted; borrow = ~final carry.
  - Logic ops are per bit; carry is unused.
  - The result bit shifts into the result register at the MSB end, so after W shifts bit 0 is in position 0.
- RUN -> DONE on the edge that processes bit W-1. Accept at edge k gives out_valid high after edge k+W; latency is W cycles.
- During RUN: in_ready=0, out_valid=0. The result port is not required to be stable.
- DONE: out_valid=1; result, flag and zero are stable.
  - DONE -> IDLE on the edge where out_ready=1. out_valid drops and in_ready rises after that edge.
  - out_ready low holds DONE indefinitely, with outputs unchanged.
- No input/output overlap: a new accept is only possible one cycle after the result handoff. The throughput limit is W+2 cycles per op.
- Reserved oc (110/111): the engine still runs W cycles and returns result=0, flag=0, zero=1.
- Counter wraps only via the state transition; it never indexes beyond W-1.
- out_valid is never asserted at the same time as in_ready.

Optional Feature:
- Macro SERIAL_ALU_OVF_EN.
- Defined: adds output port ovf (1 bit). In DONE, for add/sub, ovf = carry into MSB XOR carry out of MSB (signed two's-complement overflow); ovf=0 for other ops. Reset value is 0; held with result.
- Undefined: no ovf port, no MSB-carry register; all other behaviour is identical.

Test Plan:
- W=8, add a=0xFF b=0x01 -> result=0x00, flag=1, zero=1, out_valid first high exactly 8 cycles after accept edge.
- sub a=0x05 b=0x07 -> result=0xFE, flag=1, zero=0. Also sub a=0x07 b=0x05 -> result=0x02, flag=0.
- xor a=0xA5 b=0x0F -> 0xAA. or -> 0xAF. and/mul -> 0x05; flag=0 for all three.
- Backpressure: or 0x30|0x03, out_ready held low 3 cycles in DONE -> result=0x33 stable, out_valid=1, in_ready=0 throughout. Handoff on the 4th cycle, then in_ready=1 the next cycle.
- Assert rst_n low 3 cycles into RUN -> outputs at reset values immediately (asynchronously). The next op, add 0x10+0x20, yields 0x30 with no residue.
- Reserved oc=110 with a=0xFF b=0xFF -> result=0x00, flag=0, zero=1 after 8 cycles. With SERIAL_ALU_OVF_EN: add 0x7F+0x01 -> result=0x80, ovf=1, flag=0.
